// File: rtl/sram_axi_mux_bridge_pkg.sv
// Shared constants, FSM encoding and helpers for the SRAM-to-AXI3 mux bridge.
package sram_axi_mux_bridge_pkg;

  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StAr   = 3'd1,
    StR    = 3'd2,
    StWr   = 3'd3,
    StB    = 3'd4,
    StDone = 3'd5
  } bridge_state_e;

  // AXI AxSIZE encoding for a full-width beat of the given byte count.
  function automatic logic [2:0] axi_size(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/sram_axi_mux_bridge_rr_arbiter.sv
// Round-robin arbiter: combinational grant starting from a registered rotating pointer.
// The pointer moves one past the current grant when i_advance is high.
module sram_axi_mux_bridge_rr_arbiter #(
  parameter int unsigned N     = 2,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N-1:0]     i_req,
  input  logic             i_advance,
  output logic [N-1:0]     o_grant_oh,
  output logic [IDX_W-1:0] o_grant_idx
);

  if (N == 1) begin : g_single
    // Only one requester: grant is a pass-through and no pointer is needed.
    logic w_unused;
    assign w_unused    = i_clk ^ i_rst ^ i_advance;
    assign o_grant_oh  = i_req;
    assign o_grant_idx = '0;
  end else begin : g_multi
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W:0]   w_cand;
    logic             w_found;

    // Scan requesters starting at the pointer, wrapping, and take the first one.
    always_comb begin
      o_grant_oh  = '0;
      o_grant_idx = '0;
      w_found     = 1'b0;
      w_cand      = '0;
      for (int unsigned k = 0; k < N; k++) begin
        w_cand = {1'b0, r_ptr} + (IDX_W + 1)'(k);
        if (w_cand >= (IDX_W + 1)'(N)) begin
          w_cand = w_cand - (IDX_W + 1)'(N);
        end
        if (!w_found && i_req[w_cand[IDX_W-1:0]]) begin
          w_found                        = 1'b1;
          o_grant_idx                    = w_cand[IDX_W-1:0];
          o_grant_oh[w_cand[IDX_W-1:0]] = 1'b1;
        end
      end
    end

    // Rotate the pointer past the channel just granted.
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_ptr <= '0;
      end else if (i_advance) begin
        r_ptr <= (o_grant_idx == IDX_W'(N - 1)) ? '0 : o_grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_axi_mux_bridge.sv
// Merges NUM_CH SRAM-style request channels onto a single AXI3 master.
// Single-beat transfers, one transaction outstanding, round-robin arbitration.
// Optional feature macro: SRAM_AXI_BRIDGE_ERR_EN adds o_ch_err and sticky o_err_seen
// reporting non-OKAY rresp/bresp; without it responses are ignored.
module sram_axi_mux_bridge
  import sram_axi_mux_bridge_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  // SRAM-style request side
  input  logic [NUM_CH-1:0]              i_ch_req,
  input  logic [NUM_CH*DATA_WIDTH/8-1:0] i_ch_write_en,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]   i_ch_addr,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   i_ch_write_data,
  output logic [NUM_CH-1:0]              o_ch_done,
  output logic [DATA_WIDTH-1:0]          o_ch_read_data,
  output logic                           o_ch_busy,
`ifdef SRAM_AXI_BRIDGE_ERR_EN
  output logic                           o_ch_err,
  output logic                           o_err_seen,
`endif
  // AR
  output logic [ID_WIDTH-1:0]            o_arid,
  output logic [ADDR_WIDTH-1:0]          o_araddr,
  output logic [3:0]                     o_arlen,
  output logic [2:0]                     o_arsize,
  output logic [1:0]                     o_arburst,
  output logic [1:0]                     o_arlock,
  output logic [3:0]                     o_arcache,
  output logic [2:0]                     o_arprot,
  output logic                           o_arvalid,
  input  logic                           i_arready,
  // R
  input  logic [ID_WIDTH-1:0]            i_rid,
  input  logic [DATA_WIDTH-1:0]          i_rdata,
  input  logic [1:0]                     i_rresp,
  input  logic                           i_rlast,
  input  logic                           i_rvalid,
  output logic                           o_rready,
  // AW
  output logic [ID_WIDTH-1:0]            o_awid,
  output logic [ADDR_WIDTH-1:0]          o_awaddr,
  output logic [3:0]                     o_awlen,
  output logic [2:0]                     o_awsize,
  output logic [1:0]                     o_awburst,
  output logic [1:0]                     o_awlock,
  output logic [3:0]                     o_awcache,
  output logic [2:0]                     o_awprot,
  output logic                           o_awvalid,
  input  logic                           i_awready,
  // W
  output logic [ID_WIDTH-1:0]            o_wid,
  output logic [DATA_WIDTH-1:0]          o_wdata,
  output logic [DATA_WIDTH/8-1:0]        o_wstrb,
  output logic                           o_wlast,
  output logic                           o_wvalid,
  input  logic                           i_wready,
  // B
  input  logic [ID_WIDTH-1:0]            i_bid,
  input  logic [1:0]                     i_bresp,
  input  logic                           i_bvalid,
  output logic                           o_bready
);

  localparam int unsigned SEL_W = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [2:0]  AXI_SIZE = axi_size(SEL_W);

  bridge_state_e           r_state;
  logic [IDX_W-1:0]        r_grant;
  logic [NUM_CH-1:0]       r_grant_oh;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [SEL_W-1:0]        r_strb;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [DATA_WIDTH-1:0]   r_read_data;
  logic [NUM_CH-1:0]       r_done;
  logic                    r_arvalid;
  logic                    r_rready;
  logic                    r_awvalid;
  logic                    r_wvalid;
  logic                    r_bready;
  logic                    r_aw_done;
  logic                    r_w_done;
`ifdef SRAM_AXI_BRIDGE_ERR_EN
  logic                    r_err;
  logic                    r_err_seen;
`endif

  logic [NUM_CH-1:0]       w_grant_oh;
  logic [IDX_W-1:0]        w_grant_idx;
  logic                    w_start;
  logic [SEL_W-1:0]        w_sel_strb;
  logic                    w_aw_ok;
  logic                    w_w_ok;

  // rid/rlast/bid are not checked: only one transaction is ever outstanding.
  logic                    w_unused;
`ifdef SRAM_AXI_BRIDGE_ERR_EN
  assign w_unused = ^{i_rid, i_rlast, i_bid};
`else
  assign w_unused = ^{i_rid, i_rlast, i_bid, i_rresp, i_bresp};
`endif

  // Pointer advances at grant time; it is not consulted again until the
  // next IDLE, and a reset clears it, so this matches advancing in DONE.
  assign w_start = (r_state == StIdle) && (|i_ch_req);

  sram_axi_mux_bridge_rr_arbiter #(
    .N     (NUM_CH),
    .IDX_W (IDX_W)
  ) u_arb (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req       (i_ch_req),
    .i_advance   (w_start),
    .o_grant_oh  (w_grant_oh),
    .o_grant_idx (w_grant_idx)
  );

  assign w_sel_strb = i_ch_write_en[w_grant_idx*SEL_W +: SEL_W];
  // A channel is accepted either on an earlier cycle or by this cycle's handshake.
  assign w_aw_ok    = r_aw_done | (r_awvalid & i_awready);
  assign w_w_ok     = r_w_done  | (r_wvalid  & i_wready);

  // Bridge FSM with all bus-facing controls registered.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_grant     <= '0;
      r_grant_oh  <= '0;
      r_addr      <= '0;
      r_strb      <= '0;
      r_wdata     <= '0;
      r_read_data <= '0;
      r_done      <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
`ifdef SRAM_AXI_BRIDGE_ERR_EN
      r_err       <= 1'b0;
      r_err_seen  <= 1'b0;
`endif
    end else begin
      r_done <= '0;
`ifdef SRAM_AXI_BRIDGE_ERR_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        StIdle: begin
          if (w_start) begin
            r_grant    <= w_grant_idx;
            r_grant_oh <= w_grant_oh;
            r_addr     <= i_ch_addr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_strb     <= w_sel_strb;
            r_wdata    <= i_ch_write_data[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
            if (w_sel_strb == '0) begin
              r_arvalid <= 1'b1;
              r_state   <= StAr;
            end else begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= StWr;
            end
          end
        end
        StAr: begin
          if (i_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= StR;
          end
        end
        StR: begin
          if (i_rvalid) begin
            r_rready    <= 1'b0;
            r_read_data <= i_rdata;
            r_done      <= r_grant_oh;
`ifdef SRAM_AXI_BRIDGE_ERR_EN
            r_err       <= (i_rresp != AXI_RESP_OKAY);
            r_err_seen  <= r_err_seen | (i_rresp != AXI_RESP_OKAY);
`endif
            r_state     <= StDone;
          end
        end
        StWr: begin
          if (r_awvalid && i_awready) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (r_wvalid && i_wready) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_ok && w_w_ok) begin
            r_bready <= 1'b1;
            r_state  <= StB;
          end
        end
        StB: begin
          if (i_bvalid) begin
            r_bready   <= 1'b0;
            r_done     <= r_grant_oh;
`ifdef SRAM_AXI_BRIDGE_ERR_EN
            r_err      <= (i_bresp != AXI_RESP_OKAY);
            r_err_seen <= r_err_seen | (i_bresp != AXI_RESP_OKAY);
`endif
            r_state    <= StDone;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_ch_done      = r_done;
  assign o_ch_read_data = r_read_data;
  assign o_ch_busy      = (r_state != StIdle);
`ifdef SRAM_AXI_BRIDGE_ERR_EN
  assign o_ch_err       = r_err;
  assign o_err_seen     = r_err_seen;
`endif

  assign o_arid    = ID_WIDTH'(r_grant);
  assign o_araddr  = r_addr;
  assign o_arlen   = 4'd0;
  assign o_arsize  = AXI_SIZE;
  assign o_arburst = AXI_BURST_INCR;
  assign o_arlock  = 2'b00;
  assign o_arcache = 4'd0;
  assign o_arprot  = 3'd0;
  assign o_arvalid = r_arvalid;
  assign o_rready  = r_rready;

  assign o_awid    = ID_WIDTH'(r_grant);
  assign o_awaddr  = r_addr;
  assign o_awlen   = 4'd0;
  assign o_awsize  = AXI_SIZE;
  assign o_awburst = AXI_BURST_INCR;
  assign o_awlock  = 2'b00;
  assign o_awcache = 4'd0;
  assign o_awprot  = 3'd0;
  assign o_awvalid = r_awvalid;

  assign o_wid     = ID_WIDTH'(r_grant);
  assign o_wdata   = r_wdata;
  assign o_wstrb   = r_strb;
  assign o_wlast   = 1'b1;
  assign o_wvalid  = r_wvalid;
  assign o_bready  = r_bready;

endmodule

// File: tb/tb_sram_axi_mux_bridge.sv
// Directed testbench for sram_axi_mux_bridge (NUM_CH=2, 32-bit address/data).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sram_axi_mux_bridge;

  localparam int NCH = 2;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 4;
  localparam int SW  = DW / 8;

  logic              clk;
  logic              rst;
  logic [NCH-1:0]    ch_req;
  logic [NCH*SW-1:0] ch_write_en;
  logic [NCH*AW-1:0] ch_addr;
  logic [NCH*DW-1:0] ch_write_data;
  logic [NCH-1:0]    ch_done;
  logic [DW-1:0]     ch_read_data;
  logic              ch_busy;
`ifdef SRAM_AXI_BRIDGE_ERR_EN
  logic              ch_err;
  logic              err_seen;
`endif
  logic [IW-1:0]     arid;
  logic [AW-1:0]     araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic [1:0]        arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [IW-1:0]     rid;
  logic [DW-1:0]     rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;
  logic [IW-1:0]     awid;
  logic [AW-1:0]     awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic [1:0]        awlock;
  logic [3:0]        awcache;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [IW-1:0]     wid;
  logic [DW-1:0]     wdata;
  logic [SW-1:0]     wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;
  logic [IW-1:0]     bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  int n_checks = 0;
  int n_fail   = 0;

  sram_axi_mux_bridge #(
    .NUM_CH     (NCH),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .ID_WIDTH   (IW)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_ch_req        (ch_req),
    .i_ch_write_en   (ch_write_en),
    .i_ch_addr       (ch_addr),
    .i_ch_write_data (ch_write_data),
    .o_ch_done       (ch_done),
    .o_ch_read_data  (ch_read_data),
    .o_ch_busy       (ch_busy),
`ifdef SRAM_AXI_BRIDGE_ERR_EN
    .o_ch_err        (ch_err),
    .o_err_seen      (err_seen),
`endif
    .o_arid          (arid),
    .o_araddr        (araddr),
    .o_arlen         (arlen),
    .o_arsize        (arsize),
    .o_arburst       (arburst),
    .o_arlock        (arlock),
    .o_arcache       (arcache),
    .o_arprot        (arprot),
    .o_arvalid       (arvalid),
    .i_arready       (arready),
    .i_rid           (rid),
    .i_rdata         (rdata),
    .i_rresp         (rresp),
    .i_rlast         (rlast),
    .i_rvalid        (rvalid),
    .o_rready        (rready),
    .o_awid          (awid),
    .o_awaddr        (awaddr),
    .o_awlen         (awlen),
    .o_awsize        (awsize),
    .o_awburst       (awburst),
    .o_awlock        (awlock),
    .o_awcache       (awcache),
    .o_awprot        (awprot),
    .o_awvalid       (awvalid),
    .i_awready       (awready),
    .o_wid           (wid),
    .o_wdata         (wdata),
    .o_wstrb         (wstrb),
    .o_wlast         (wlast),
    .o_wvalid        (wvalid),
    .i_wready        (wready),
    .i_bid           (bid),
    .i_bresp         (bresp),
    .i_bvalid        (bvalid),
    .o_bready        (bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    ch_req = '0; ch_write_en = '0; ch_addr = '0; ch_write_data = '0;
    arready = 0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 0;
    awready = 0; wready = 0; bid = '0; bresp = 2'b00; bvalid = 0;
    tick(); tick();

    // Reset state
    check("rst_done",    ch_done, 2'b00);
    check("rst_busy",    ch_busy, 1'b0);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_awvalid", awvalid, 1'b0);
    check("rst_wvalid",  wvalid,  1'b0);
    check("rst_rready",  rready,  1'b0);
    check("rst_bready",  bready,  1'b0);
    rst = 1'b0;
    tick();

    // 1: read on ch0, zero-wait slave
    ch_addr[31:0] = 32'h1FC0_0000;
    ch_req = 2'b01;
    tick();  // c0 grant
    check("t1_arvalid", arvalid, 1'b1);
    check("t1_araddr",  araddr,  32'h1FC0_0000);
    check("t1_arid",    arid,    4'd0);
    check("t1_arlen",   arlen,   4'd0);
    check("t1_arsize",  arsize,  3'd2);
    check("t1_arburst", arburst, 2'b01);
    check("t1_busy",    ch_busy, 1'b1);
    arready = 1;
    tick();  // c2
    check("t1_arvalid_drop", arvalid, 1'b0);
    check("t1_rready",       rready,  1'b1);
    arready = 0; rvalid = 1; rdata = 32'hDEAD_BEEF;
    tick();  // c3
    check("t1_done",  ch_done,      2'b01);
    check("t1_rdata", ch_read_data, 32'hDEAD_BEEF);
    rvalid = 0; rdata = '0; ch_req = 2'b00;
    tick();
    check("t1_done_clear", ch_done, 2'b00);
    check("t1_idle",       ch_busy, 1'b0);

    // 2: write on ch1, awready 3 cycles late, wready immediate
    ch_addr[63:32] = 32'h0000_0010;
    ch_write_en[7:4] = 4'b0011;
    ch_write_data[63:32] = 32'h1234_5678;
    wready = 1; awready = 0;
    ch_req = 2'b10;
    tick();  // c1
    check("t2_awvalid_c1", awvalid, 1'b1);
    check("t2_wvalid_c1",  wvalid,  1'b1);
    check("t2_awid",       awid,    4'd1);
    check("t2_wid",        wid,     4'd1);
    check("t2_awaddr",     awaddr,  32'h0000_0010);
    check("t2_wstrb",      wstrb,   4'b0011);
    check("t2_wdata",      wdata,   32'h1234_5678);
    check("t2_wlast",      wlast,   1'b1);
    check("t2_arvalid",    arvalid, 1'b0);
    tick();
    check("t2_wvalid_drop", wvalid,  1'b0);
    check("t2_awvalid_c2",  awvalid, 1'b1);
    tick();
    check("t2_awvalid_c3",  awvalid, 1'b1);
    awready = 1;
    tick();
    check("t2_awvalid_drop", awvalid, 1'b0);
    check("t2_bready",       bready,  1'b1);
    check("t2_no_early_done", ch_done, 2'b00);
    awready = 0; bvalid = 1; bresp = 2'b00;
    tick();
    check("t2_done", ch_done, 2'b10);
    bvalid = 0; ch_req = 2'b00; wready = 0;
    tick();
    check("t2_done_once", ch_done, 2'b00);

    // 3: both channels requesting continuously, reads with always-ready slave
    ch_write_en = '0;
    ch_addr = {32'h0000_4000, 32'h0000_3000};
    arready = 1; rvalid = 1; rdata = 32'h0BAD_F00D;
    ch_req = 2'b11;
    for (int n = 0; n < 6; n++) begin
      int t;
      t = 0;
      while (ch_done == 2'b00 && t < 12) begin
        tick();
        t++;
      end
      check($sformatf("t3_grant%0d", n), ch_done, (n % 2 == 0) ? 2'b01 : 2'b10);
      if (n == 5) ch_req = 2'b00;
      tick();
    end
    arready = 0; rvalid = 0; rdata = '0;
    tick();

    // 4: reset asserted in R with rvalid withheld
    ch_addr[31:0] = 32'h0000_0100;
    ch_req = 2'b01;
    tick();  // AR
    arready = 1;
    tick();  // R
    check("t4_rready_before", rready, 1'b1);
    arready = 0; rst = 1;
    tick();
    check("t4_rready", rready,  1'b0);
    check("t4_busy",   ch_busy, 1'b0);
    check("t4_done",   ch_done, 2'b00);
    check("t4_arvalid", arvalid, 1'b0);
    rst = 0;
    tick();
    check("t4_regrant_arvalid", arvalid, 1'b1);
    check("t4_regrant_araddr",  araddr,  32'h0000_0100);
    arready = 1;
    tick();
    arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D;
    tick();
    check("t4_regrant_done",  ch_done,      2'b01);
    check("t4_regrant_rdata", ch_read_data, 32'hCAFE_F00D);
    rvalid = 0; ch_req = 2'b00;
    tick();

    // 5: zero strobe on ch1 is a read
    ch_addr[63:32] = 32'h0000_2000;
    ch_write_en[7:4] = 4'b0000;
    ch_write_data[63:32] = 32'hFFFF_FFFF;
    ch_req = 2'b10;
    tick();
    check("t5_arvalid", arvalid, 1'b1);
    check("t5_arid",    arid,    4'd1);
    check("t5_araddr",  araddr,  32'h0000_2000);
    check("t5_awvalid", awvalid, 1'b0);
    arready = 1;
    tick();
    check("t5_awvalid_r", awvalid, 1'b0);
    check("t5_rready",    rready,  1'b1);
    arready = 0; rvalid = 1; rdata = 32'h55AA_55AA;
    tick();
    check("t5_done",    ch_done,      2'b10);
    check("t5_rdata",   ch_read_data, 32'h55AA_55AA);
    check("t5_awvalid_d", awvalid,    1'b0);
    rvalid = 0; ch_req = 2'b00;
    tick();

`ifdef SRAM_AXI_BRIDGE_ERR_EN
    // 6: SLVERR on write response
    ch_write_en[3:0] = 4'hF;
    ch_write_data[31:0] = 32'hA5A5_A5A5;
    awready = 1; wready = 1;
    ch_req = 2'b01;
    tick();  // WR
    tick();  // B
    awready = 0; wready = 0; bvalid = 1; bresp = 2'b10;
    tick();
    check("t6_done",     ch_done,  2'b01);
    check("t6_err",      ch_err,   1'b1);
    check("t6_err_seen", err_seen, 1'b1);
    bvalid = 0; bresp = 2'b00; ch_req = 2'b00;
    tick();
    check("t6_err_pulse", ch_err,   1'b0);
    check("t6_sticky",    err_seen, 1'b1);
    rst = 1;
    tick();
    rst = 0;
    check("t6_sticky_rst", err_seen, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
